// File: rtl/pic24_icsp_pkg.sv
// Shared types and opcode constants for the PIC24 ICSP command sequencer and its step table.
package pic24_icsp_pkg;

    typedef enum logic [1:0] {
        OP_SIX    = 2'd0,
        OP_REGOUT = 2'd1,
        OP_READ   = 2'd2,
        OP_RSTVEC = 2'd3
    } op_t;

    typedef enum logic [1:0] {
        S_WAIT_ENG = 2'd0,
        S_IDLE     = 2'd1,
        S_ISSUE    = 2'd2,
        S_WAIT     = 2'd3
    } state_t;

    localparam logic CMD_SIX    = 1'b0;
    localparam logic CMD_REGOUT = 1'b1;

    localparam logic [23:0] NOP          = 24'h000000;
    localparam logic [23:0] TBLRDL_W6_W7 = 24'hBA0B96;
    localparam logic [23:0] MOV_LIT_BASE = 24'h200000;

    localparam logic [3:0] REG_W0 = 4'd0;
    localparam logic [3:0] REG_W6 = 4'd6;
    localparam logic [3:0] REG_W7 = 4'd7;

    typedef struct packed {
        logic        cmd;
        logic [23:0] instr;
        logic        last;
    } step_t;

    // MOV #lit16,Wn encodes as {4'h2, lit16, reg}
    function automatic logic [23:0] mov_lit(input logic [15:0] lit16, input logic [3:0] rg);
        return MOV_LIT_BASE | {4'h0, lit16, rg};
    endfunction

endpackage

// File: rtl/pic24_icsp_steprom.sv
// Combinational step table: maps (op, step, addr, instr) to the engine command, opcode and last-step flag.
module pic24_icsp_steprom
    import pic24_icsp_pkg::*;
#(
    parameter logic [15:0] VISI_ADDR    = 16'h0784,
    parameter logic [23:0] TBLPAG_MOVOP = 24'h8802A0,
    parameter logic [23:0] RESET_VECTOR = 24'h040200
) (
    input  op_t         op,
    input  logic [3:0]  step,
    input  logic [23:0] addr,
    input  logic [23:0] instr,
    output step_t       entry
);

    logic [15:0] addr_lo;

    // program-memory word addresses are even; bit 0 is dropped
    assign addr_lo = addr[15:0] & 16'hFFFE;

    always_comb begin
        entry = '{cmd: CMD_SIX, instr: NOP, last: 1'b0};
        case (op)
            OP_SIX: begin
                entry.instr = instr;
                entry.last  = 1'b1;
            end
            OP_REGOUT: begin
                if (step == 4'd0) entry.cmd  = CMD_REGOUT;
                else              entry.last = 1'b1;
            end
            OP_RSTVEC: begin
                if (step == 4'd0) entry.instr = RESET_VECTOR;
                else              entry.last  = 1'b1;
            end
            OP_READ: begin
                case (step)
                    4'd0:    entry.instr = mov_lit({8'h00, addr[23:16]}, REG_W0);
                    4'd1:    entry.instr = TBLPAG_MOVOP;
                    4'd2:    entry.instr = mov_lit(addr_lo, REG_W6);
                    4'd3:    entry.instr = mov_lit(VISI_ADDR, REG_W7);
                    4'd5:    entry.instr = TBLRDL_W6_W7;
                    4'd8:    entry.cmd   = CMD_REGOUT;
                    4'd9:    entry.last  = 1'b1;
                    default: entry.instr = NOP;
                endcase
            end
            default: entry = '{cmd: CMD_SIX, instr: NOP, last: 1'b1};
        endcase
    end

endmodule

// File: rtl/pic24_icsp_sequencer.sv
// Expands host requests into paced ICSP engine SIX/REGOUT steps and returns REGOUT data as a one-cycle pulse.
module pic24_icsp_sequencer
    import pic24_icsp_pkg::*;
#(
    parameter logic [15:0] VISI_ADDR    = 16'h0784,
    parameter logic [23:0] TBLPAG_MOVOP = 24'h8802A0,
    parameter logic [23:0] RESET_VECTOR = 24'h040200
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [1:0]  req_op,
    input  logic [23:0] req_addr,
    input  logic [23:0] req_instr,
    output logic        rsp_valid,
    output logic [15:0] rsp_data,
    output logic        busy,
    output logic [23:0] eng_instr,
    output logic        eng_cmd,
    output logic        eng_valid,
    input  logic        eng_ready,
    input  logic        eng_dvalid,
    input  logic [15:0] eng_dout
);

    state_t      state;
    logic        eng_rdy_flag;
    op_t         op_q;
    logic [23:0] addr_q;
    logic [23:0] instr_q;
    logic [3:0]  step;
    step_t       entry;
    logic        rdy_now;

    pic24_icsp_steprom #(
        .VISI_ADDR    (VISI_ADDR),
        .TBLPAG_MOVOP (TBLPAG_MOVOP),
        .RESET_VECTOR (RESET_VECTOR)
    ) u_steprom (
        .op    (op_q),
        .step  (step),
        .addr  (addr_q),
        .instr (instr_q),
        .entry (entry)
    );

    // react to the ready pulse in the same cycle so rsp_valid trails it by one cycle
    assign rdy_now = eng_rdy_flag | eng_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= S_WAIT_ENG;
            eng_rdy_flag <= 1'b0;
            op_q         <= OP_SIX;
            addr_q       <= '0;
            instr_q      <= '0;
            step         <= '0;
            req_ready    <= 1'b0;
            rsp_valid    <= 1'b0;
            rsp_data     <= '0;
            busy         <= 1'b0;
            eng_instr    <= '0;
            eng_cmd      <= 1'b0;
            eng_valid    <= 1'b0;
        end else begin
            rsp_valid <= 1'b0;
            if (eng_valid)      eng_rdy_flag <= 1'b0;
            else if (eng_ready) eng_rdy_flag <= 1'b1;

            case (state)
                S_WAIT_ENG: begin
                    if (rdy_now) begin
                        req_ready <= 1'b1;
                        state     <= S_IDLE;
                    end
                end
                S_IDLE: begin
                    if (req_valid) begin
                        op_q      <= op_t'(req_op);
                        addr_q    <= req_addr;
                        instr_q   <= req_instr;
                        step      <= '0;
                        req_ready <= 1'b0;
                        busy      <= 1'b1;
                        state     <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    eng_valid <= 1'b1;
                    eng_cmd   <= entry.cmd;
                    eng_instr <= entry.instr;
                    state     <= S_WAIT;
                end
                S_WAIT: begin
                    eng_valid <= 1'b0;
                    if (eng_cmd == CMD_REGOUT && eng_dvalid) rsp_data <= eng_dout;
                    // a flag left over from before the issue is ignored while eng_valid is still high
                    if (!eng_valid && rdy_now) begin
                        if (entry.last) begin
                            rsp_valid <= (op_q == OP_REGOUT) || (op_q == OP_READ);
                            busy      <= 1'b0;
                            req_ready <= 1'b1;
                            state     <= S_IDLE;
                        end else begin
                            step  <= step + 4'd1;
                            state <= S_ISSUE;
                        end
                    end
                end
                default: state <= S_WAIT_ENG;
            endcase
        end
    end

endmodule

// File: tb/tb_pic24_icsp_sequencer.sv
// Bench for pic24_icsp_sequencer: engine model with boot delay, random requests checked against a step-list model.
module tb_pic24_icsp_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_op;
    logic [23:0] req_addr;
    logic [23:0] req_instr;
    logic        rsp_valid;
    logic [15:0] rsp_data;
    logic        busy;
    logic [23:0] eng_instr;
    logic        eng_cmd;
    logic        eng_valid;
    logic        eng_ready;
    logic        eng_dvalid;
    logic [15:0] eng_dout;

    pic24_icsp_sequencer dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_addr   (req_addr),
        .req_instr  (req_instr),
        .rsp_valid  (rsp_valid),
        .rsp_data   (rsp_data),
        .busy       (busy),
        .eng_instr  (eng_instr),
        .eng_cmd    (eng_cmd),
        .eng_valid  (eng_valid),
        .eng_ready  (eng_ready),
        .eng_dvalid (eng_dvalid),
        .eng_dout   (eng_dout)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int fails  = 0;
    int boot_delay = 100;

    // observed engine issues {busy, cmd, instr}, responses and rsp latency after the last ready
    logic [25:0] mon_q[$];
    logic [15:0] rsp_q[$];
    int          rsp_lat_q[$];
    int          cyc = 0;
    int          last_rdy = 0;

    logic [24:0] exp_q[$];
    bit          exp_rsp;
    int          nv0, nr0;

    // engine model: one ready pulse 5 cycles after each eng_valid, plus one after boot
    initial begin : engine
        int pend;
        int boot_cnt;
        logic pend_regout;
        pend = 0;
        boot_cnt = -1;
        pend_regout = 1'b0;
        eng_ready = 1'b0;
        eng_dvalid = 1'b0;
        eng_dout = 16'h0;
        forever begin
            @(posedge clk);
            #1;
            eng_ready = 1'b0;
            eng_dvalid = 1'b0;
            eng_dout = 16'h0;
            if (rst) begin
                pend = 0;
                boot_cnt = boot_delay;
            end else begin
                if (boot_cnt > 0) begin
                    boot_cnt--;
                    if (boot_cnt == 0) begin
                        eng_ready = 1'b1;
                        boot_cnt = -1;
                    end
                end
                if (pend > 0) begin
                    pend--;
                    if (pend == 0) begin
                        eng_ready = 1'b1;
                        if (pend_regout) begin
                            eng_dvalid = 1'b1;
                            eng_dout = 16'hA55A;
                        end
                    end
                end
                if (eng_valid) begin
                    pend = 5;
                    pend_regout = eng_cmd;
                end
            end
        end
    end

    always @(negedge clk) begin
        cyc = cyc + 1;
        if (eng_ready) last_rdy = cyc;
        if (eng_valid) mon_q.push_back({busy, eng_cmd, eng_instr});
        if (rsp_valid) begin
            rsp_q.push_back(rsp_data);
            rsp_lat_q.push_back(cyc - last_rdy);
        end
    end

    function automatic logic [23:0] mov(input int lit, input int r);
        int v;
        v = 32'h200000 + (lit % 65536) * 16 + r;
        return v[23:0];
    endfunction

    // reference: the ordered list of engine steps each host op should expand into
    task automatic build_expected(input logic [1:0] op, input logic [23:0] a, input logic [23:0] ins);
        exp_q.delete();
        exp_rsp = 1'b0;
        case (op)
            2'd0: exp_q.push_back({1'b0, ins});
            2'd1: begin
                exp_q.push_back({1'b1, 24'h000000});
                exp_q.push_back({1'b0, 24'h000000});
                exp_rsp = 1'b1;
            end
            2'd2: begin
                exp_q.push_back({1'b0, mov(int'(a[23:16]), 0)});
                exp_q.push_back({1'b0, 24'h8802A0});
                exp_q.push_back({1'b0, mov(int'(a[15:0]) / 2 * 2, 6)});
                exp_q.push_back({1'b0, mov(16'h0784, 7)});
                exp_q.push_back({1'b0, 24'h000000});
                exp_q.push_back({1'b0, 24'hBA0B96});
                exp_q.push_back({1'b0, 24'h000000});
                exp_q.push_back({1'b0, 24'h000000});
                exp_q.push_back({1'b1, 24'h000000});
                exp_q.push_back({1'b0, 24'h000000});
                exp_rsp = 1'b1;
            end
            default: begin
                exp_q.push_back({1'b0, 24'h040200});
                exp_q.push_back({1'b0, 24'h000000});
            end
        endcase
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // runs one op to completion; ok=0 if the sequencer never became ready
    task automatic do_op(input logic [1:0] op, input logic [23:0] a, input logic [23:0] ins,
                         input bit hold, output bit ok);
        int n;
        ok = 1'b1;
        n = 0;
        while (req_ready !== 1'b1 && n < 1000) begin tick(); n++; end
        if (req_ready !== 1'b1) ok = 1'b0;
        nv0 = mon_q.size();
        nr0 = rsp_q.size();
        build_expected(op, a, ins);
        req_op = op; req_addr = a; req_instr = ins; req_valid = 1'b1;
        tick();
        if (hold) begin
            req_op = 2'd0;
            req_instr = 24'h123456;
        end else begin
            req_valid = 1'b0;
        end
        n = 0;
        while (req_ready !== 1'b1 && n < 2000) begin tick(); n++; end
        req_valid = 1'b0;
        if (req_ready !== 1'b1) ok = 1'b0;
        repeat (2) tick();
    endtask

    task automatic test_reset();
        bit early;
        int n;
        boot_delay = 100;
        rst = 1'b1; req_valid = 1'b0; req_op = 2'd0; req_addr = '0; req_instr = '0;
        repeat (3) tick();
        checks++;
        if ({req_ready, rsp_valid, rsp_data, busy, eng_instr, eng_cmd, eng_valid} !== 44'h0) begin
            fails++;
            $display("FAIL reset_outputs: got rdy=%b rv=%b rd=%h busy=%b ins=%h cmd=%b v=%b, want all zero",
                     req_ready, rsp_valid, rsp_data, busy, eng_instr, eng_cmd, eng_valid);
        end
        rst = 1'b0;
        early = 1'b0;
        repeat (90) begin
            tick();
            if (req_ready !== 1'b0 || eng_valid !== 1'b0) early = 1'b1;
        end
        checks++;
        if (early) begin fails++; $display("FAIL boot_wait: req_ready/eng_valid rose before first engine ready, want 0"); end
        checks++;
        if (mon_q.size() != 0) begin fails++; $display("FAIL boot_no_issue: %0d eng_valids, want 0", mon_q.size()); end
        n = 0;
        while (req_ready !== 1'b1 && n < 200) begin tick(); n++; end
        checks++;
        if (req_ready !== 1'b1) begin fails++; $display("FAIL boot_ready: req_ready=%b, want 1", req_ready); end
    endtask

    task automatic test_six();
        bit ok;
        logic [23:0] ins;
        for (int i = 0; i < 4; i++) begin
            ins = (i == 0) ? 24'hABCDEF : 24'($urandom);
            do_op(2'd0, 24'($urandom), ins, 1'b0, ok);
            checks++;
            if (!ok) begin fails++; $display("FAIL six_done[%0d]: req_ready not returned", i); end
            checks++;
            if (mon_q.size() - nv0 != 1) begin fails++; $display("FAIL six_count[%0d]: %0d issues, want 1", i, mon_q.size() - nv0); end
            else begin
                checks++;
                if (mon_q[nv0][24:0] !== exp_q[0]) begin
                    fails++; $display("FAIL six_step[%0d]: got %h, want %h", i, mon_q[nv0][24:0], exp_q[0]);
                end
            end
            checks++;
            if (rsp_q.size() != nr0) begin fails++; $display("FAIL six_rsp[%0d]: %0d rsp_valid, want 0", i, rsp_q.size() - nr0); end
        end
    endtask

    // covers OP_READ, OP_REGOUT and OP_RSTVEC against the model step list
    task automatic test_seq(input logic [1:0] op, input logic [23:0] a, input bit hold, input string name);
        bit ok;
        do_op(op, a, 24'($urandom), hold, ok);
        checks++;
        if (!ok) begin fails++; $display("FAIL %s_done: req_ready not returned", name); end
        checks++;
        if (mon_q.size() - nv0 != exp_q.size()) begin
            fails++; $display("FAIL %s_count: %0d issues, want %0d", name, mon_q.size() - nv0, exp_q.size());
        end else begin
            for (int k = 0; k < exp_q.size(); k++) begin
                checks++;
                if (mon_q[nv0 + k] !== {1'b1, exp_q[k]}) begin
                    fails++;
                    $display("FAIL %s_step%0d: got busy/cmd/instr %h, want %h", name, k, mon_q[nv0 + k], {1'b1, exp_q[k]});
                end
            end
        end
        checks++;
        if (rsp_q.size() - nr0 != (exp_rsp ? 1 : 0)) begin
            fails++; $display("FAIL %s_rsp_count: %0d, want %0d", name, rsp_q.size() - nr0, exp_rsp);
        end else if (exp_rsp) begin
            checks++;
            if (rsp_q[nr0] !== 16'hA55A) begin fails++; $display("FAIL %s_rsp_data: got %h, want a55a", name, rsp_q[nr0]); end
            checks++;
            if (rsp_lat_q[nr0] != 1) begin fails++; $display("FAIL %s_rsp_lat: got %0d, want 1", name, rsp_lat_q[nr0]); end
        end
        checks++;
        if (busy !== 1'b0) begin fails++; $display("FAIL %s_busy_end: busy=%b, want 0", name, busy); end
    endtask

    task automatic test_read();
        test_seq(2'd2, 24'h012346, 1'b0, "read_fixed");
        for (int i = 0; i < 3; i++) test_seq(2'd2, 24'($urandom), 1'b0, "read_rand");
        test_seq(2'd1, 24'h0, 1'b0, "regout");
    endtask

    task automatic test_rstvec();
        test_seq(2'd3, 24'h0, 1'b0, "rstvec");
    endtask

    task automatic test_back_to_back();
        test_seq(2'd2, 24'($urandom), 1'b1, "read_hold");
        test_seq(2'd3, 24'h0, 1'b0, "b2b_rstvec");
        test_seq(2'd1, 24'h0, 1'b0, "b2b_regout");
        test_seq(2'd2, 24'($urandom), 1'b0, "b2b_read");
    endtask

    task automatic test_reset_mid();
        int n;
        bit bad;
        bit ok;
        n = 0;
        while (req_ready !== 1'b1 && n < 1000) begin tick(); n++; end
        nv0 = mon_q.size();
        nr0 = rsp_q.size();
        req_op = 2'd2; req_addr = 24'($urandom); req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        n = 0;
        while (mon_q.size() - nv0 < 4 && n < 500) begin tick(); n++; end
        checks++;
        if (mon_q.size() - nv0 < 4) begin fails++; $display("FAIL midrst_reach: %0d issues, want 4", mon_q.size() - nv0); end
        rst = 1'b1;
        #1;
        checks++;
        if ({req_ready, rsp_valid, rsp_data, busy, eng_instr, eng_cmd, eng_valid} !== 44'h0) begin
            fails++;
            $display("FAIL midrst_outputs: got rdy=%b rv=%b rd=%h busy=%b ins=%h cmd=%b v=%b, want all zero",
                     req_ready, rsp_valid, rsp_data, busy, eng_instr, eng_cmd, eng_valid);
        end
        repeat (3) tick();
        rst = 1'b0;
        nv0 = mon_q.size();
        bad = 1'b0;
        repeat (50) begin
            tick();
            if (req_ready !== 1'b0 || eng_valid !== 1'b0) bad = 1'b1;
        end
        checks++;
        if (bad || mon_q.size() != nv0) begin fails++; $display("FAIL midrst_wait_eng: activity before engine ready, want none"); end
        checks++;
        if (rsp_q.size() != nr0) begin fails++; $display("FAIL midrst_rsp: %0d rsp_valid, want 0", rsp_q.size() - nr0); end
        do_op(2'd0, 24'h0, 24'($urandom), 1'b0, ok);
        checks++;
        if (!ok || mon_q.size() - nv0 != 1) begin
            fails++; $display("FAIL midrst_recover: ok=%b issues=%0d, want 1/1", ok, mon_q.size() - nv0);
        end
    endtask

    initial begin
        test_reset();
        test_six();
        test_read();
        test_rstvec();
        test_back_to_back();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
